sp_fifo_ctrl: RTL and testbench

SP_FIFO_CTRL -- requirements
Module: sp_fifo_ctrl

---
 rtl/sp_fifo_ctrl.sv | 153 +++++++++++++++
 tb/tb_sp_fifo_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sp_fifo_ctrl.sv
// FIFO controller that drives an external single-port RAM.
// Optional sticky overflow/underflow flags are added when SP_FIFO_CTRL_ERR_FLAG_EN is defined.
module sp_fifo_ctrl #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned ADDRESS_WIDTH = 10,
    parameter int unsigned MEMORY_DEPTH  = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [DATA_WIDTH-1:0]    push_data,
    output logic                     push_ready,
    input  logic                     pop,
    output logic [DATA_WIDTH-1:0]    pop_data,
    output logic                     pop_valid,
    output logic                     full,
    output logic                     empty,
    output logic [ADDRESS_WIDTH:0]   count,
    output logic [ADDRESS_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0]    ram_data_in,
    output logic                     ram_wr,
    output logic                     ram_rd,
    input  logic [DATA_WIDTH-1:0]    ram_out
`ifdef SP_FIFO_CTRL_ERR_FLAG_EN
    ,
    output logic                     overflow,
    output logic                     underflow
`endif
);

    localparam logic [ADDRESS_WIDTH-1:0] PtrLast   = ADDRESS_WIDTH'(MEMORY_DEPTH - 1);
    localparam logic [ADDRESS_WIDTH-1:0] PtrOne    = ADDRESS_WIDTH'(1);
    localparam logic [ADDRESS_WIDTH:0]   CountFull = (ADDRESS_WIDTH + 1)'(MEMORY_DEPTH);
    localparam logic [ADDRESS_WIDTH:0]   CountOne  = (ADDRESS_WIDTH + 1)'(1);

    typedef enum logic [1:0] {StIdle, StWrite, StRead} state_e;

    state_e                   r_state;
    logic [ADDRESS_WIDTH-1:0] r_rd_ptr;
    logic [ADDRESS_WIDTH-1:0] r_wr_ptr;

    state_e                   w_state_next;
    logic [ADDRESS_WIDTH-1:0] w_rd_ptr_next;
    logic [ADDRESS_WIDTH-1:0] w_wr_ptr_next;
    logic [ADDRESS_WIDTH:0]   w_count_next;
    logic                     w_full_next;
    logic                     w_empty_next;
    logic [DATA_WIDTH-1:0]    w_pop_data_next;
    logic                     w_pop_valid_next;
    logic [ADDRESS_WIDTH-1:0] w_ram_address_next;
    logic [DATA_WIDTH-1:0]    w_ram_data_in_next;
    logic                     w_ram_wr_next;
    logic                     w_ram_rd_next;
    logic                     w_pop_accept;

    // Pop wins over a simultaneous push; the push waits for the next idle cycle.
    assign w_pop_accept = (r_state == StIdle) && pop && !empty;
    assign push_ready   = (r_state == StIdle) && !full && !(pop && !empty);

    always_comb begin
        w_state_next       = r_state;
        w_rd_ptr_next      = r_rd_ptr;
        w_wr_ptr_next      = r_wr_ptr;
        w_count_next       = count;
        w_pop_data_next    = pop_data;
        w_pop_valid_next   = 1'b0;
        w_ram_address_next = ram_address;
        w_ram_data_in_next = ram_data_in;
        w_ram_wr_next      = 1'b0;
        w_ram_rd_next      = 1'b0;

        case (r_state)
            StIdle: begin
                if (w_pop_accept) begin
                    w_state_next       = StRead;
                    w_ram_address_next = r_rd_ptr;
                    w_ram_rd_next      = 1'b1;
                end else if (push && push_ready) begin
                    w_state_next       = StWrite;
                    w_ram_address_next = r_wr_ptr;
                    w_ram_data_in_next = push_data;
                    w_ram_wr_next      = 1'b1;
                end
            end
            StWrite: begin
                w_state_next  = StIdle;
                w_wr_ptr_next = (r_wr_ptr == PtrLast) ? '0 : r_wr_ptr + PtrOne;
                w_count_next  = count + CountOne;
            end
            StRead: begin
                w_state_next     = StIdle;
                w_pop_data_next  = ram_out;
                w_pop_valid_next = 1'b1;
                w_rd_ptr_next    = (r_rd_ptr == PtrLast) ? '0 : r_rd_ptr + PtrOne;
                w_count_next     = count - CountOne;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase

        w_full_next  = (w_count_next == CountFull);
        w_empty_next = (w_count_next == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= StIdle;
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            count       <= '0;
            full        <= 1'b0;
            empty       <= 1'b1;
            pop_data    <= '0;
            pop_valid   <= 1'b0;
            ram_address <= '0;
            ram_data_in <= '0;
            ram_wr      <= 1'b0;
            ram_rd      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_rd_ptr    <= w_rd_ptr_next;
            r_wr_ptr    <= w_wr_ptr_next;
            count       <= w_count_next;
            full        <= w_full_next;
            empty       <= w_empty_next;
            pop_data    <= w_pop_data_next;
            pop_valid   <= w_pop_valid_next;
            ram_address <= w_ram_address_next;
            ram_data_in <= w_ram_data_in_next;
            ram_wr      <= w_ram_wr_next;
            ram_rd      <= w_ram_rd_next;
        end
    end

`ifdef SP_FIFO_CTRL_ERR_FLAG_EN
    // Sticky until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if ((r_state == StIdle) && push && full) begin
                overflow <= 1'b1;
            end
            if ((r_state == StIdle) && pop && empty) begin
                underflow <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sp_fifo_ctrl.sv
// Self-checking bench for sp_fifo_ctrl: depth-4 FIFO over a behavioural single-port RAM.
module tb_sp_fifo_ctrl;

    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 3;
    localparam int unsigned DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          push;
    logic [DW-1:0] push_data;
    logic          push_ready;
    logic          pop;
    logic [DW-1:0] pop_data;
    logic          pop_valid;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_data_in;
    logic          ram_wr;
    logic          ram_rd;
    logic [DW-1:0] ram_out;
`ifdef SP_FIFO_CTRL_ERR_FLAG_EN
    logic          overflow;
    logic          underflow;
`endif

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] exp_q [$];
    int            n_checks = 0;
    int            n_errors = 0;
    int            mdl_count = 0;
    int            mdl_wr = 0;
    int            mdl_rd = 0;

    always #5 clk = ~clk;

    sp_fifo_ctrl #(
        .DATA_WIDTH    (DW),
        .ADDRESS_WIDTH (AW),
        .MEMORY_DEPTH  (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .push        (push),
        .push_data   (push_data),
        .push_ready  (push_ready),
        .pop         (pop),
        .pop_data    (pop_data),
        .pop_valid   (pop_valid),
        .full        (full),
        .empty       (empty),
        .count       (count),
        .ram_address (ram_address),
        .ram_data_in (ram_data_in),
        .ram_wr      (ram_wr),
        .ram_rd      (ram_rd),
        .ram_out     (ram_out)
`ifdef SP_FIFO_CTRL_ERR_FLAG_EN
        ,
        .overflow    (overflow),
        .underflow   (underflow)
`endif
    );

    // Asynchronous-read RAM, write on the clock edge.
    always @(posedge clk) if (ram_wr) mem[ram_address] <= ram_data_in;
    assign ram_out = mem[ram_address];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            check("ram_wr_rd_exclusive", {31'd0, ram_wr & ram_rd}, 32'd0);
            if (pop_valid) begin
                if (exp_q.size() == 0) check("pop_valid_spurious", 32'd1, 32'd0);
                else check("pop_data", {24'd0, pop_data}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic check_status(input string tag);
        check({tag, "_count"}, {28'd0, count}, mdl_count);
        check({tag, "_full"}, {31'd0, full}, {31'd0, mdl_count == DEPTH});
        check({tag, "_empty"}, {31'd0, empty}, {31'd0, mdl_count == 0});
    endtask

    // Called at a negedge with the FSM idle; returns at a negedge with the FSM idle.
    task automatic do_push(input logic [DW-1:0] d);
        int n = 0;
        push = 1'b1;
        push_data = d;
        #1;
        while (!push_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!push_ready) begin
            check("push_ready_timeout", 32'd0, 32'd1);
            push = 1'b0;
        end else begin
            exp_q.push_back(d);
            @(posedge clk);
            #1 push = 1'b0;
            @(negedge clk);
            check("write_ram_wr", {31'd0, ram_wr}, 32'd1);
            check("write_ram_rd", {31'd0, ram_rd}, 32'd0);
            check("write_address", {29'd0, ram_address}, mdl_wr);
            check("write_data", {24'd0, ram_data_in}, {24'd0, d});
            mdl_wr = (mdl_wr + 1) % DEPTH;
            mdl_count++;
            @(negedge clk);
            check("idle_ram_wr", {31'd0, ram_wr}, 32'd0);
            check_status("push");
        end
    endtask

    task automatic do_pop();
        pop = 1'b1;
        #1;
        @(posedge clk);
        #1 pop = 1'b0;
        @(negedge clk);
        check("read_ram_rd", {31'd0, ram_rd}, 32'd1);
        check("read_ram_wr", {31'd0, ram_wr}, 32'd0);
        check("read_address", {29'd0, ram_address}, mdl_rd);
        mdl_rd = (mdl_rd + 1) % DEPTH;
        mdl_count--;
        @(negedge clk);
        check("pop_valid", {31'd0, pop_valid}, 32'd1);
        check("idle_ram_rd", {31'd0, ram_rd}, 32'd0);
        check_status("pop");
    endtask

    task automatic pop_when_empty();
        pop = 1'b1;
        #1;
        @(posedge clk);
        #1 pop = 1'b0;
        @(negedge clk);
        check("empty_pop_ram_rd", {31'd0, ram_rd}, 32'd0);
        check("empty_pop_valid", {31'd0, pop_valid}, 32'd0);
        @(negedge clk);
        check("empty_pop_valid_late", {31'd0, pop_valid}, 32'd0);
        check_status("empty_pop");
`ifdef SP_FIFO_CTRL_ERR_FLAG_EN
        check("underflow", {31'd0, underflow}, 32'd1);
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        reset = 1'b1;
        push = 1'b0;
        pop = 1'b0;
        push_data = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);

        check_status("reset");
        check("reset_pop_valid", {31'd0, pop_valid}, 32'd0);
        check("reset_pop_data", {24'd0, pop_data}, 32'd0);
        check("reset_ram_wr", {31'd0, ram_wr}, 32'd0);
        check("reset_ram_rd", {31'd0, ram_rd}, 32'd0);
        check("reset_ram_address", {29'd0, ram_address}, 32'd0);
        check("reset_ram_data_in", {24'd0, ram_data_in}, 32'd0);
        check("reset_push_ready", {31'd0, push_ready}, 32'd1);
`ifdef SP_FIFO_CTRL_ERR_FLAG_EN
        check("reset_overflow", {31'd0, overflow}, 32'd0);
        check("reset_underflow", {31'd0, underflow}, 32'd0);
`endif

        pop_when_empty();

        do_push(8'hA5);
        do_pop();

        do_push(8'h11);
        do_push(8'h22);
        do_push(8'h33);
        do_push(8'h44);
        check("full_flag", {31'd0, full}, 32'd1);

        // Fifth push against a full FIFO must be refused.
        push = 1'b1;
        push_data = 8'h55;
        #1 check("full_push_ready", {31'd0, push_ready}, 32'd0);
        @(posedge clk);
        #1 push = 1'b0;
        @(negedge clk);
        check("full_push_ram_wr", {31'd0, ram_wr}, 32'd0);
        check_status("full_push");
`ifdef SP_FIFO_CTRL_ERR_FLAG_EN
        check("overflow", {31'd0, overflow}, 32'd1);
`endif

        repeat (4) do_pop();

        for (int i = 1; i <= 6; i++) begin
            do_push(8'(i));
            do_pop();
        end

        // Simultaneous push and pop with two words stored: the read goes first.
        do_push(8'hC1);
        do_push(8'hC2);
        push = 1'b1;
        pop = 1'b1;
        push_data = 8'hC3;
        #1 check("both_push_ready", {31'd0, push_ready}, 32'd0);
        @(posedge clk);
        #1 pop = 1'b0;
        @(negedge clk);
        check("both_read_ram_rd", {31'd0, ram_rd}, 32'd1);
        check("both_read_address", {29'd0, ram_address}, mdl_rd);
        check("both_read_push_ready", {31'd0, push_ready}, 32'd0);
        mdl_rd = (mdl_rd + 1) % DEPTH;
        mdl_count--;
        @(negedge clk);
        check("both_pop_valid", {31'd0, pop_valid}, 32'd1);
        check_status("both_after_read");
        do_push(8'hC3);
        repeat (2) do_pop();

        // Reset during the write cycle aborts the word.
        push = 1'b1;
        push_data = 8'h5A;
        #1 check("abort_push_ready", {31'd0, push_ready}, 32'd1);
        @(posedge clk);
        #1 push = 1'b0;
        check("abort_write_ram_wr", {31'd0, ram_wr}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        exp_q.delete();
        mdl_count = 0;
        mdl_wr = 0;
        mdl_rd = 0;
        @(negedge clk);
        check_status("abort");
        check("abort_ram_wr", {31'd0, ram_wr}, 32'd0);
        check("abort_pop_valid", {31'd0, pop_valid}, 32'd0);
        pop_when_empty();

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
